// File: rtl/user_module_bitserial_alu_seq.sv
// ============================================================================
// Module   : user_module_bitserial_alu_seq
// Purpose  : Bit-serial operand sequencer feeding a 1-bit ALU slice.
//            Operands A and B are shifted in serially, MSB first. They are
//            then streamed LSB-first through a 1-bit ALU with one bit per
//            clock. The ALU can do AND, NOT B, OR, or ADD with a carry flop.
//            The WIDTH-bit result is shown as one hex digit on a 7-segment
//            display, and the decimal point shows the final carry.
// Ports    : io_in[0]    clk, rising-edge clock
//            io_in[1]    rst_n, synchronous active-low reset
//            io_in[2]    din, serial operand data
//            io_in[3]    shift_en, shift din into the operand register
//            io_in[5:4]  op: 00 AND, 01 NOT B, 10 OR, 11 ADD
//            io_in[6]    start, begin a serial operation (level-sampled)
//            io_in[7]    cin, ADD carry-in (sampled with start)
//            io_out[6:0] {g,f,e,d,c,b,a} active-high segments of result
//            io_out[7]   dp = final carry
// Params   : WIDTH  operand/result width, legal range 1..4
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module user_module_bitserial_alu_seq #(
  parameter int WIDTH = 4
) (
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_NOTB = 2'b01;
  localparam logic [1:0] OP_OR   = 2'b10;
  localparam logic [1:0] OP_ADD  = 2'b11;

  localparam logic [2:0] C_LAST_BIT = 3'(WIDTH - 1);

  // Unpack the pin bundle.
  logic       clk;
  logic       rst_n;
  logic       din;
  logic       shift_en;
  logic [1:0] op;
  logic       start;
  logic       cin;

  assign clk      = io_in[0];
  assign rst_n    = io_in[1];
  assign din      = io_in[2];
  assign shift_en = io_in[3];
  assign op       = io_in[5:4];
  assign start    = io_in[6];
  assign cin      = io_in[7];

  logic [1:0]         state_q,  state_d;
  logic [2*WIDTH-1:0] sr_q,     sr_d;
  logic [WIDTH-1:0]   opa_q,    opa_d;
  logic [WIDTH-1:0]   opb_q,    opb_d;
  logic [1:0]         op_q,     op_d;
  logic [WIDTH-1:0]   res_sh_q, res_sh_d;
  logic [2:0]         cnt_q,    cnt_d;
  logic               c_q,      c_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               carry_q,  carry_d;

  // The ALU slice works on the current LSB of each operand.
  logic             alu_a;
  logic             alu_b;
  logic             alu_r;
  logic             alu_cout;
  logic [WIDTH-1:0] res_next;
  logic [WIDTH-1:0] r_at_msb;

  assign alu_a = opa_q[0];
  assign alu_b = opb_q[0];

  always_comb begin
    alu_r    = 1'b0;
    alu_cout = 1'b0;
    case (op_q)
      OP_AND:  alu_r = alu_a & alu_b;
      OP_NOTB: alu_r = ~alu_b;
      OP_OR:   alu_r = alu_a | alu_b;
      OP_ADD: begin
        alu_r    = alu_a ^ alu_b ^ c_q;
        alu_cout = (alu_a & alu_b) | (alu_a & c_q) | (alu_b & c_q);
      end
      default: alu_r = 1'b0;
    endcase
  end

  // New bit enters at the MSB so the LSB-first stream lands in order.
  // This is built without part-selects so that WIDTH=1 stays legal.
  always_comb begin
    r_at_msb            = '0;
    r_at_msb[WIDTH-1]   = alu_r;
    res_next            = (res_sh_q >> 1) | r_at_msb;
  end

  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    op_d     = op_q;
    res_sh_d = res_sh_q;
    cnt_d    = cnt_q;
    c_d      = c_q;
    result_d = result_q;
    carry_d  = carry_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          // start takes priority over shift_en; sr is not shifted.
          state_d = S_RUN;
          opa_d   = sr_q[2*WIDTH-1:WIDTH];
          opb_d   = sr_q[WIDTH-1:0];
          op_d    = op;
          cnt_d   = 3'd0;
          c_d     = (op == OP_ADD) ? cin : 1'b0;
        end else if (shift_en) begin
          sr_d    = {sr_q[2*WIDTH-2:0], din};
          state_d = S_IDLE;
        end
      end

      S_RUN: begin
        // start and shift_en are deliberately ignored while streaming.
        opa_d    = opa_q >> 1;
        opb_d    = opb_q >> 1;
        res_sh_d = res_next;
        c_d      = (op_q == OP_ADD) ? alu_cout : 1'b0;
        cnt_d    = cnt_q + 3'd1;
        if (cnt_q == C_LAST_BIT) begin
          // The display registers update only here, so partial results never show.
          result_d = res_next;
          carry_d  = (op_q == OP_ADD) ? alu_cout : 1'b0;
          state_d  = S_DONE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      sr_q     <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      op_q     <= OP_AND;
      res_sh_q <= '0;
      cnt_q    <= 3'd0;
      c_q      <= 1'b0;
      result_q <= '0;
      carry_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      sr_q     <= sr_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      op_q     <= op_d;
      res_sh_q <= res_sh_d;
      cnt_q    <= cnt_d;
      c_q      <= c_d;
      result_q <= result_d;
      carry_q  <= carry_d;
    end
  end

  // Hex digit for the display. Unused upper bits read as zero when WIDTH < 4.
  logic [3:0] digit;
  logic [6:0] seg;

  always_comb begin
    digit              = '0;
    digit[WIDTH-1:0]   = result_q;
  end

  always_comb begin
    seg = 7'h00;
    case (digit)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      4'hF: seg = 7'h71;
      default: seg = 7'h00;
    endcase
  end

  assign io_out = {carry_q, seg};

endmodule

`default_nettype wire

// File: tb/tb_user_module_bitserial_alu_seq.sv
// ============================================================================
// Module   : tb_user_module_bitserial_alu_seq
// Purpose  : Directed self-checking bench for user_module_bitserial_alu_seq.
//            Expected display codes are computed by hand from the operand
//            values and the segment table.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_user_module_bitserial_alu_seq;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b0;
  logic       din      = 1'b0;
  logic       shift_en = 1'b0;
  logic [1:0] op       = 2'b00;
  logic       start    = 1'b0;
  logic       cin      = 1'b0;

  logic [7:0] io_in;
  logic [7:0] io_out;

  int checks   = 0;
  int failures = 0;

  assign io_in = {cin, start, op, shift_en, din, rst_n, clk};

  user_module_bitserial_alu_seq #(.WIDTH(4)) dut (
    .io_in  (io_in),
    .io_out (io_out)
  );

  always #5 clk = ~clk;

  localparam logic [7:0] C_IDLE = 8'd0;
  localparam logic [7:0] C_RUN  = 8'd1;
  localparam logic [7:0] C_DONE = 8'd2;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One active edge; the outputs are sampled 1 time unit later.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic shift4(input logic [3:0] v);
    for (int i = 3; i >= 0; i--) begin
      din      = v[i];
      shift_en = 1'b1;
      cyc();
    end
    shift_en = 1'b0;
    din      = 1'b0;
  endtask

  task automatic load(input logic [3:0] a, input logic [3:0] b);
    shift4(a);
    shift4(b);
  endtask

  task automatic launch(input logic [1:0] o, input logic ci);
    op    = o;
    cin   = ci;
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  // After the start edge: three edges with the old display, then the result.
  task automatic finish_run(input string tag, input logic [7:0] prev, input logic [7:0] exp);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk({tag, "_hold"}, io_out, prev);
      chk({tag, "_inrun"}, 8'(dut.state_q), C_RUN);
    end
    cyc();
    chk(tag, io_out, exp);
    chk({tag, "_done"}, 8'(dut.state_q), C_DONE);
  endtask

  initial begin
    // 1: reset
    rst_n = 1'b0;
    cyc();
    chk("reset_out", io_out, 8'h3F);
    chk("reset_sr", dut.sr_q, 8'h00);
    chk("reset_state", 8'(dut.state_q), C_IDLE);
    rst_n = 1'b1;

    // 2: ADD 7 + 9 = 16 -> digit 0 with carry
    load(4'b0111, 4'b1001);
    launch(2'b11, 1'b0);
    chk("add1_start_out", io_out, 8'h3F);
    finish_run("add_7_9", 8'h3F, 8'hBF);

    // 3: logic ops, carry 0
    load(4'b1100, 4'b1010);
    launch(2'b00, 1'b1);   // cin ignored for AND
    finish_run("and", 8'hBF, 8'h7F);
    load(4'b0000, 4'b0101);
    launch(2'b01, 1'b0);
    finish_run("notb", 8'h7F, 8'h77);
    load(4'b0001, 4'b0110);
    launch(2'b10, 1'b0);
    finish_run("or", 8'h77, 8'h07);

    // 4: ADD with carry-in
    load(4'b1111, 4'b0000);
    launch(2'b11, 1'b1);
    finish_run("add_f_0_c", 8'h07, 8'hBF);
    load(4'b0011, 4'b0100);
    launch(2'b11, 1'b1);
    finish_run("add_3_4_c", 8'hBF, 8'h7F);

    // 5: disturbances during RUN have no effect
    load(4'b0111, 4'b1001);
    launch(2'b11, 1'b0);
    cyc();
    chk("dist_hold1", io_out, 8'h7F);
    start = 1'b1; shift_en = 1'b1; din = 1'b1; op = 2'b00; cin = 1'b1;
    cyc();
    start = 1'b0; shift_en = 1'b0; din = 1'b0;
    chk("dist_hold2", io_out, 8'h7F);
    chk("dist_state", 8'(dut.state_q), C_RUN);
    cyc();
    chk("dist_hold3", io_out, 8'h7F);
    cyc();
    chk("dist_result", io_out, 8'hBF);
    chk("dist_done", 8'(dut.state_q), C_DONE);
    chk("dist_sr", dut.sr_q, 8'h79);

    // Back-to-back: start held in DONE relaunches with the current sr (ADD 7+9+1 = 17)
    launch(2'b11, 1'b1);
    chk("b2b_state", 8'(dut.state_q), C_RUN);
    finish_run("b2b", 8'hBF, 8'h86);

    // 6: reset in the middle of RUN aborts
    load(4'b1100, 4'b1010);
    launch(2'b00, 1'b0);
    cyc();
    cyc();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    chk("midrst_out", io_out, 8'h3F);
    chk("midrst_state", 8'(dut.state_q), C_IDLE);
    chk("midrst_sr", dut.sr_q, 8'h00);
    cyc();
    chk("midrst_stay", io_out, 8'h3F);
    load(4'b0001, 4'b0110);
    launch(2'b10, 1'b0);
    finish_run("post_rst_or", 8'h3F, 8'h07);

    // start together with shift_en in IDLE: start wins, sr is not shifted
    load(4'b0111, 4'b1001);
    shift_en = 1'b1;
    din      = 1'b1;
    launch(2'b11, 1'b0);
    shift_en = 1'b0;
    din      = 1'b0;
    chk("ss_state", 8'(dut.state_q), C_RUN);
    chk("ss_sr", dut.sr_q, 8'h79);
    finish_run("ss_add", 8'h07, 8'hBF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
